// File: rtl/uart_pkg.sv
// Shared UART receive-path definitions: FSM encodings, oversample geometry, RCREG FIFO entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_BIT9  = 3'd3,
        RX_STOP  = 3'd4
    } rx_state_t;

    localparam int RX_OVERSAMPLE = 16;
    localparam int RX_TICK_W     = $clog2(RX_OVERSAMPLE);

    // Majority sample points inside one bit time, and the last tick of a bit.
    localparam logic [RX_TICK_W-1:0] RX_TICK_S0   = RX_TICK_W'(7);
    localparam logic [RX_TICK_W-1:0] RX_TICK_S1   = RX_TICK_W'(8);
    localparam logic [RX_TICK_W-1:0] RX_TICK_S2   = RX_TICK_W'(9);
    localparam logic [RX_TICK_W-1:0] RX_TICK_LAST = RX_TICK_W'(RX_OVERSAMPLE - 1);

    localparam int RX_FIFO_DEPTH = 2;
    localparam int RX_ENTRY_W    = 10;

    typedef struct packed {
        logic       ferr;
        logic       bit9;
        logic [7:0] data;
    } rx_entry_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// RCREG holding FIFO, 2 x 10-bit; head entry is a register so the core sees registered data.
// Latency: push/pop visible at the outputs the cycle after the clock edge that applies them.
// Backpressure: none upstream; a push into a full FIFO without a same-cycle pop is dropped (caller flags overrun).
// Ports: clk, rst_n; push_vld/push_dat in; pop_vld in; head_dat, ne (non-empty), full out.
module uart_rx_fifo
    import uart_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_vld,
    input  rx_entry_t push_dat,
    input  logic      pop_vld,
    output rx_entry_t head_dat,
    output logic      ne,
    output logic      full
);

    localparam logic [1:0] DEPTH = 2'(RX_FIFO_DEPTH);

    rx_entry_t  slot0;
    rx_entry_t  slot1;
    logic [1:0] cnt;
    logic [1:0] cnt_nxt;
    logic       pop_eff;
    logic       push_ok;

    // Pop is applied before push, so a full FIFO with a pop accepts the new entry.
    assign pop_eff = pop_vld && (cnt != 2'd0);
    assign push_ok = push_vld && ((cnt != DEPTH) || pop_eff);
    assign full    = (cnt == DEPTH);

    always_comb begin
        cnt_nxt = cnt;
        if (push_ok && !pop_eff) begin
            cnt_nxt = cnt + 2'd1;
        end else if (!push_ok && pop_eff) begin
            cnt_nxt = cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
            slot1 <= '0;
            cnt   <= 2'd0;
            ne    <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            ne  <= (cnt_nxt != 2'd0);
            case ({push_ok, pop_eff})
                2'b10: begin
                    if (cnt == 2'd0) slot0 <= push_dat;
                    else             slot1 <= push_dat;
                end
                // Popping the last entry leaves slot0 stale on purpose: the
                // core keeps reading the last value while the FIFO is empty.
                2'b01: begin
                    if (cnt == DEPTH) slot0 <= slot1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        slot0 <= push_dat;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_dat = slot0;

endmodule

// File: rtl/uart_rx_rsr.sv
// UART receive shift register: RXD sync, 16x majority sampling, 8/9-bit framing, RCREG FIFO, FERR/OERR.
// Latency: frame pushed on the stop-bit tick-9 edge; RCREG/RCIF outputs update the following cycle.
// Backpressure: none on the line; a frame arriving into a full FIFO is dropped and sets sticky OERR.
// Ports: clk, rst_n, UART_RXD, rx_sample_en, cren, rx9, aden, rcreg_rd_en in;
//        rcreg_reg_out, rx9d_out, ferr_out, oerr_out, rxif_set_en, rx_busy out (all registered).
module uart_rx_rsr
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       UART_RXD,
    input  logic       rx_sample_en,
    input  logic       cren,
    input  logic       rx9,
    input  logic       aden,
    input  logic       rcreg_rd_en,
    output logic [7:0] rcreg_reg_out,
    output logic       rx9d_out,
    output logic       ferr_out,
    output logic       oerr_out,
    output logic       rxif_set_en,
    output logic       rx_busy
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_s;
    logic                   rxd_q;

    rx_state_t              state;
    logic [RX_TICK_W-1:0]   tick_cnt;
    logic [2:0]             bit_cnt;
    logic [2:0]             samp;
    logic [8:0]             rsr;
    logic                   oerr;

    logic                   third;
    logic                   maj;
    logic                   bit_end;
    logic                   stop_eval;
    logic                   keep;
    logic                   push_vld;
    logic                   ovf;
    rx_entry_t              push_dat;
    rx_entry_t              head_dat;
    logic                   fifo_ne;
    logic                   fifo_full;

    // Synchroniser idles high so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            rxd_q  <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], UART_RXD};
            rxd_q  <= rxd_s;
        end
    end

    assign rxd_s = sync_q[SYNC_STAGES-1];

    // STOP is judged at tick 9, before the tick-9 sample is registered, so
    // the live synchronised bit stands in for the third vote there.
    assign third     = (tick_cnt == RX_TICK_S2) ? rxd_s : samp[2];
    assign maj       = maj3(samp[0], samp[1], third);
    assign bit_end   = rx_sample_en && (tick_cnt == RX_TICK_LAST);
    assign stop_eval = (state == RX_STOP) && rx_sample_en && (tick_cnt == RX_TICK_S2);

    // Address-detect drops 9-bit data frames (9th bit clear).
    assign keep     = !(rx9 && aden && !rsr[8]);
    assign push_vld = stop_eval && cren && keep;
    assign ovf      = push_vld && fifo_full && !rcreg_rd_en;

    assign push_dat.ferr = !maj;
    assign push_dat.bit9 = rx9 ? rsr[8] : 1'b0;
    assign push_dat.data = rsr[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RX_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= 3'd0;
            samp     <= 3'b111;
            rsr      <= 9'd0;
            oerr     <= 1'b0;
            rx_busy  <= 1'b0;
        end else if (!cren) begin
            state   <= RX_IDLE;
            oerr    <= 1'b0;
            rx_busy <= 1'b0;
        end else begin
            if (ovf) oerr <= 1'b1;

            if (rx_sample_en) begin
                if (tick_cnt == RX_TICK_S0) samp[0] <= rxd_s;
                if (tick_cnt == RX_TICK_S1) samp[1] <= rxd_s;
                if (tick_cnt == RX_TICK_S2) samp[2] <= rxd_s;
                if (state != RX_IDLE) tick_cnt <= tick_cnt + 1'b1;
            end

            case (state)
                RX_IDLE: begin
                    if (!oerr && rxd_q && !rxd_s) begin
                        state    <= RX_START;
                        tick_cnt <= '0;
                        rx_busy  <= 1'b1;
                    end
                end
                RX_START: begin
                    if (bit_end) begin
                        if (maj) begin
                            state   <= RX_IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            state   <= RX_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                end
                RX_DATA: begin
                    if (bit_end) begin
                        rsr[7:0] <= {maj, rsr[7:1]};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= rx9 ? RX_BIT9 : RX_STOP;
                    end
                end
                RX_BIT9: begin
                    if (bit_end) begin
                        rsr[8] <= maj;
                        state  <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    // Leave at tick 9 so a start edge right after a short
                    // stop bit is still caught in IDLE.
                    if (stop_eval) begin
                        state   <= RX_IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= RX_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

    uart_rx_fifo u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (rcreg_rd_en),
        .head_dat (head_dat),
        .ne       (fifo_ne),
        .full     (fifo_full)
    );

    assign rcreg_reg_out = head_dat.data;
    assign rx9d_out      = head_dat.bit9;
    assign ferr_out      = head_dat.ferr;
    assign oerr_out      = oerr;
    assign rxif_set_en   = fifo_ne;

endmodule

// File: tb/tb_uart_rx_rsr.sv
// Directed bench for uart_rx_rsr: frames driven bit-by-bit at 16 clocks per bit.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_rsr;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       UART_RXD = 1'b1;
    logic       rx_sample_en = 1'b1;
    logic       cren = 1'b1;
    logic       rx9 = 1'b0;
    logic       aden = 1'b0;
    logic       rcreg_rd_en = 1'b0;
    logic [7:0] rcreg_reg_out;
    logic       rx9d_out;
    logic       ferr_out;
    logic       oerr_out;
    logic       rxif_set_en;
    logic       rx_busy;

    int total = 0;
    int bad   = 0;

    uart_rx_rsr #(.SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .UART_RXD      (UART_RXD),
        .rx_sample_en  (rx_sample_en),
        .cren          (cren),
        .rx9           (rx9),
        .aden          (aden),
        .rcreg_rd_en   (rcreg_rd_en),
        .rcreg_reg_out (rcreg_reg_out),
        .rx9d_out      (rx9d_out),
        .ferr_out      (ferr_out),
        .oerr_out      (oerr_out),
        .rxif_set_en   (rxif_set_en),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    // Advance n clocks and land 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // rd_at >= 0 pulses rcreg_rd_en rd_at clocks into the stop bit (8-bit frames:
    // 12 lands on the push edge with a 2-stage synchroniser).
    task automatic send_frame(input logic [7:0] d, input logic b9, input logic use9,
                              input logic stop_v, input int rd_at);
        UART_RXD = 1'b0;
        step(16);
        for (int i = 0; i < 8; i++) begin
            UART_RXD = d[i];
            step(16);
        end
        if (use9) begin
            UART_RXD = b9;
            step(16);
        end
        UART_RXD = stop_v;
        if (rd_at >= 0) begin
            step(rd_at);
            rcreg_rd_en = 1'b1;
            step(1);
            rcreg_rd_en = 1'b0;
            step(16 - rd_at - 1);
        end else begin
            step(16);
        end
        UART_RXD = 1'b1;
        step(4);
    endtask

    task automatic pop();
        rcreg_rd_en = 1'b1;
        step(1);
        rcreg_rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        total++; if (rcreg_reg_out !== 8'h00) begin bad++; $display("FAIL reset_rcreg got %h want 00", rcreg_reg_out); end
        total++; if (rx9d_out !== 1'b0) begin bad++; $display("FAIL reset_rx9d got %b want 0", rx9d_out); end
        total++; if (ferr_out !== 1'b0) begin bad++; $display("FAIL reset_ferr got %b want 0", ferr_out); end
        total++; if (oerr_out !== 1'b0) begin bad++; $display("FAIL reset_oerr got %b want 0", oerr_out); end
        total++; if (rxif_set_en !== 1'b0) begin bad++; $display("FAIL reset_rxif got %b want 0", rxif_set_en); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", rx_busy); end
        rst_n = 1'b1;
        step(4);
    endtask

    task automatic test_basic();
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'hA3, 1'b0, 1'b0, 1'b1, -1);
        total++; if (rxif_set_en !== 1'b1) begin bad++; $display("FAIL basic_rxif got %b want 1", rxif_set_en); end
        total++; if (rcreg_reg_out !== 8'h55) begin bad++; $display("FAIL basic_first got %h want 55", rcreg_reg_out); end
        total++; if (ferr_out !== 1'b0) begin bad++; $display("FAIL basic_ferr got %b want 0", ferr_out); end
        pop();
        total++; if (rcreg_reg_out !== 8'hA3) begin bad++; $display("FAIL basic_second got %h want a3", rcreg_reg_out); end
        total++; if (rxif_set_en !== 1'b1) begin bad++; $display("FAIL basic_rxif2 got %b want 1", rxif_set_en); end
        pop();
        total++; if (rxif_set_en !== 1'b0) begin bad++; $display("FAIL basic_empty got %b want 0", rxif_set_en); end
        pop();
        total++; if (rcreg_reg_out !== 8'hA3) begin bad++; $display("FAIL basic_hold got %h want a3", rcreg_reg_out); end
    endtask

    task automatic test_glitch();
        UART_RXD = 1'b0;
        step(5);
        UART_RXD = 1'b1;
        step(3);
        total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy got %b want 1", rx_busy); end
        step(40);
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_idle got %b want 0", rx_busy); end
        total++; if (rxif_set_en !== 1'b0) begin bad++; $display("FAIL glitch_rxif got %b want 0", rxif_set_en); end
    endtask

    task automatic test_ferr();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1);
        total++; if (rcreg_reg_out !== 8'h3C) begin bad++; $display("FAIL ferr_data got %h want 3c", rcreg_reg_out); end
        total++; if (ferr_out !== 1'b1) begin bad++; $display("FAIL ferr_flag got %b want 1", ferr_out); end
        pop();
        total++; if (rxif_set_en !== 1'b0) begin bad++; $display("FAIL ferr_pop got %b want 0", rxif_set_en); end
    endtask

    task automatic test_overrun();
        send_frame(8'h01, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'h02, 1'b0, 1'b0, 1'b1, -1);
        total++; if (oerr_out !== 1'b0) begin bad++; $display("FAIL ovr_pre got %b want 0", oerr_out); end
        send_frame(8'h03, 1'b0, 1'b0, 1'b1, -1);
        total++; if (oerr_out !== 1'b1) begin bad++; $display("FAIL ovr_set got %b want 1", oerr_out); end
        send_frame(8'h04, 1'b0, 1'b0, 1'b1, -1);
        total++; if (oerr_out !== 1'b1) begin bad++; $display("FAIL ovr_sticky got %b want 1", oerr_out); end
        total++; if (rcreg_reg_out !== 8'h01) begin bad++; $display("FAIL ovr_head got %h want 01", rcreg_reg_out); end
        cren = 1'b0;
        step(1);
        cren = 1'b1;
        total++; if (oerr_out !== 1'b0) begin bad++; $display("FAIL ovr_clear got %b want 0", oerr_out); end
        total++; if (rxif_set_en !== 1'b1) begin bad++; $display("FAIL ovr_keep got %b want 1", rxif_set_en); end
        pop();
        total++; if (rcreg_reg_out !== 8'h02) begin bad++; $display("FAIL ovr_second got %h want 02", rcreg_reg_out); end
        pop();
        total++; if (rxif_set_en !== 1'b0) begin bad++; $display("FAIL ovr_drain got %b want 0", rxif_set_en); end
        send_frame(8'h05, 1'b0, 1'b0, 1'b1, -1);
        total++; if (rcreg_reg_out !== 8'h05) begin bad++; $display("FAIL ovr_resume got %h want 05", rcreg_reg_out); end
        total++; if (rxif_set_en !== 1'b1) begin bad++; $display("FAIL ovr_resume_rxif got %b want 1", rxif_set_en); end
        pop();
    endtask

    task automatic test_aden();
        rx9  = 1'b1;
        aden = 1'b1;
        send_frame(8'h7E, 1'b0, 1'b1, 1'b1, -1);
        total++; if (rxif_set_en !== 1'b0) begin bad++; $display("FAIL aden_drop got %b want 0", rxif_set_en); end
        send_frame(8'h81, 1'b1, 1'b1, 1'b1, -1);
        total++; if (rxif_set_en !== 1'b1) begin bad++; $display("FAIL aden_rxif got %b want 1", rxif_set_en); end
        total++; if (rcreg_reg_out !== 8'h81) begin bad++; $display("FAIL aden_data got %h want 81", rcreg_reg_out); end
        total++; if (rx9d_out !== 1'b1) begin bad++; $display("FAIL aden_rx9d got %b want 1", rx9d_out); end
        pop();
        rx9  = 1'b0;
        aden = 1'b0;
    endtask

    task automatic test_same_cycle();
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'h99, 1'b0, 1'b0, 1'b1, 12);
        total++; if (oerr_out !== 1'b0) begin bad++; $display("FAIL same_oerr got %b want 0", oerr_out); end
        total++; if (rcreg_reg_out !== 8'h22) begin bad++; $display("FAIL same_head got %h want 22", rcreg_reg_out); end
        pop();
        total++; if (rcreg_reg_out !== 8'h99) begin bad++; $display("FAIL same_last got %h want 99", rcreg_reg_out); end
        pop();
        total++; if (rxif_set_en !== 1'b0) begin bad++; $display("FAIL same_empty got %b want 0", rxif_set_en); end
    endtask

    task automatic test_reset_mid();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, -1);
        total++; if (rcreg_reg_out !== 8'h5A) begin bad++; $display("FAIL mid_pre got %h want 5a", rcreg_reg_out); end
        UART_RXD = 1'b0;
        step(40);
        total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL mid_busy got %b want 1", rx_busy); end
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (rcreg_reg_out !== 8'h00) begin bad++; $display("FAIL mid_rcreg got %h want 00", rcreg_reg_out); end
        total++; if (rxif_set_en !== 1'b0) begin bad++; $display("FAIL mid_rxif got %b want 0", rxif_set_en); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL mid_busy0 got %b want 0", rx_busy); end
        total++; if ({rx9d_out, ferr_out, oerr_out} !== 3'b000) begin bad++; $display("FAIL mid_flags got %b want 000", {rx9d_out, ferr_out, oerr_out}); end
        UART_RXD = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_ferr();
        test_overrun();
        test_aden();
        test_same_cycle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
